regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle between the two writeback sources, decode and the register file.
interface regfile_wb_arbiter_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NREG   = 32
) ();
  localparam int unsigned SEL_W = $clog2(NREG);

  logic              a_valid;
  logic [SEL_W-1:0]  a_sel;
  logic [WORD_W-1:0] a_dat;
  logic              a_ready;
  logic              b_valid;
  logic [SEL_W-1:0]  b_sel;
  logic [WORD_W-1:0] b_dat;
  logic              b_ready;
  logic              WEN;
  logic [SEL_W-1:0]  wsel;
  logic [WORD_W-1:0] wdat;
  logic [SEL_W-1:0]  rsel1;
  logic [SEL_W-1:0]  rsel2;
  logic              hazard1;
  logic              hazard2;
  logic [15:0]       conflict_cnt;

  modport slave (
    input  a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, rsel1, rsel2,
    output a_ready, b_ready, WEN, wsel, wdat, hazard1, hazard2, conflict_cnt
  );

  modport master (
    output a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, rsel1, rsel2,
    input  a_ready, b_ready, WEN, wsel, wdat, hazard1, hazard2, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-entry writeback arbiter: holds one ALU and one load result, serialises them onto the
// single register-file write port, and flags read hazards against pending writes.
module regfile_wb_arbiter #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NREG   = 32
) (
  input logic                 clk,
  input logic                 nrst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NREG);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // holding entries; hage_x set means "younger than the other valid entry"
  logic              hv_a, hv_b;
  logic              hage_a, hage_b;
  logic [SEL_W-1:0]  hsel_a, hsel_b;
  logic [WORD_W-1:0] hdat_a, hdat_b;
  logic              prio;
  logic [CNT_W-1:0]  cnt;

  logic              hv_a_n, hv_b_n;
  logic              hage_a_n, hage_b_n;
  logic [SEL_W-1:0]  hsel_a_n, hsel_b_n;
  logic [WORD_W-1:0] hdat_a_n, hdat_b_n;
  logic              prio_n;
  logic [CNT_W-1:0]  cnt_n;

  logic rdy_a_c, rdy_b_c, load_a_c, load_b_c;
  logic both_c, gnt_a_c, gnt_b_c;

  // handshake and grant selection from entry state only
  always_comb begin
    rdy_a_c  = !hv_a && !nrst;
    rdy_b_c  = !hv_b && !nrst;
    load_a_c = bus.a_valid && rdy_a_c && (bus.a_sel != '0);
    load_b_c = bus.b_valid && rdy_b_c && (bus.b_sel != '0);
    both_c   = hv_a && hv_b;
    gnt_a_c  = 1'b0;
    gnt_b_c  = 1'b0;
    if (!nrst) begin
      if (both_c) begin
        // same target keeps write-after-write order; otherwise round-robin
        if (hsel_a == hsel_b) gnt_a_c = !hage_a;
        else                  gnt_a_c = !prio;
        gnt_b_c = !gnt_a_c;
      end else begin
        gnt_a_c = hv_a;
        gnt_b_c = hv_b;
      end
    end
  end

  always_comb begin
    bus.a_ready = rdy_a_c;
    bus.b_ready = rdy_b_c;
    bus.WEN     = gnt_a_c || gnt_b_c;
    bus.wsel    = '0;
    bus.wdat    = '0;
    if (gnt_a_c) begin
      bus.wsel = hsel_a;
      bus.wdat = hdat_a;
    end else if (gnt_b_c) begin
      bus.wsel = hsel_b;
      bus.wdat = hdat_b;
    end
    bus.hazard1 = !nrst && (bus.rsel1 != '0) &&
                  ((hv_a && (hsel_a == bus.rsel1)) || (hv_b && (hsel_b == bus.rsel1)));
    bus.hazard2 = !nrst && (bus.rsel2 != '0) &&
                  ((hv_a && (hsel_a == bus.rsel2)) || (hv_b && (hsel_b == bus.rsel2)));
    bus.conflict_cnt = cnt;
  end

  // next entry state: grant clears, accept loads, age tracks load order
  always_comb begin
    hv_a_n   = hv_a;
    hv_b_n   = hv_b;
    hage_a_n = hage_a;
    hage_b_n = hage_b;
    hsel_a_n = hsel_a;
    hsel_b_n = hsel_b;
    hdat_a_n = hdat_a;
    hdat_b_n = hdat_b;
    prio_n   = prio;
    cnt_n    = cnt;

    if (gnt_a_c) begin
      hv_a_n   = 1'b0;
      hage_a_n = 1'b0;
      hage_b_n = 1'b0;
    end
    if (gnt_b_c) begin
      hv_b_n   = 1'b0;
      hage_b_n = 1'b0;
      hage_a_n = 1'b0;
    end

    if (load_a_c) begin
      hv_a_n   = 1'b1;
      hsel_a_n = bus.a_sel;
      hdat_a_n = bus.a_dat;
      hage_a_n = hv_b && !gnt_b_c;
    end
    if (load_b_c) begin
      hv_b_n   = 1'b1;
      hsel_b_n = bus.b_sel;
      hdat_b_n = bus.b_dat;
      hage_b_n = (hv_a && !gnt_a_c) || load_a_c;
    end

    if (gnt_a_c || gnt_b_c) prio_n = gnt_a_c;
    if (both_c && (cnt != CNT_MAX)) cnt_n = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      hv_a   <= 1'b0;
      hv_b   <= 1'b0;
      hage_a <= 1'b0;
      hage_b <= 1'b0;
      hsel_a <= '0;
      hsel_b <= '0;
      hdat_a <= '0;
      hdat_b <= '0;
      prio   <= 1'b0;
      cnt    <= '0;
    end else begin
      hv_a   <= hv_a_n;
      hv_b   <= hv_b_n;
      hage_a <= hage_a_n;
      hage_b <= hage_b_n;
      hsel_a <= hsel_a_n;
      hsel_b <= hsel_b_n;
      hdat_a <= hdat_a_n;
      hdat_b <= hdat_b_n;
      prio   <= prio_n;
      cnt    <= cnt_n;
    end
  end
endmodule
